// File: rtl/pipelined_core_gen.sv
// Four-stage (ID/EX/MEM/WB) datapath fed by a valid/ready instruction stream.
// Internal 8x regfile, data memory, CCR, optional forwarding and load-use interlock.
module pipelined_core_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int DMEM_DEPTH = 256,
    parameter bit FORWARD_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid,
    input  logic [15:0]           instr,
    output logic                  instr_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [2:0]            ccr,
    input  logic [2:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    localparam int AW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_ADDI = 4'd6;
    localparam logic [3:0] OP_LDM  = 4'd7;
    localparam logic [3:0] OP_STD  = 4'd8;
    localparam logic [3:0] OP_OUT  = 4'd9;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef struct packed {
        logic [3:0] op;
        logic [2:0] rd;
        logic [2:0] rs1;
        logic [2:0] rs2;
        word_t      imm;
        word_t      v1;
        word_t      v2;
        word_t      vd;
    } ex_t;

    typedef struct packed {
        logic          we;
        logic          st;
        logic          ld;
        logic          is_out;
        logic [2:0]    rd;
        word_t         res;
        logic [AW-1:0] addr;
        word_t         wdata;
    } mem_t;

    typedef struct packed {
        logic       we;
        logic [2:0] rd;
        word_t      res;
    } wb_t;

    function automatic logic writes_rd(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_LDM);
    endfunction

    function automatic logic src_hit(input logic [2:0] r, input logic [2:0] s1, input logic [2:0] s2,
                                     input logic [2:0] sd, input logic u1, input logic u2, input logic ud);
        return (u1 && s1 == r) || (u2 && s2 == r) || (ud && sd == r);
    endfunction

    // [0]=ID [1]=EX [2]=MEM [3]=WB
    logic [3:0]                  vld_pipe;
    logic [15:0]                 id_instr;
    ex_t                         ex_q, ex_d;
    mem_t                        mem_q, mem_d;
    wb_t                         wb_q, wb_d;
    logic [7:0][DATA_WIDTH-1:0]  rf;
    word_t                       dmem [DMEM_DEPTH];
    logic [2:0]                  ccr_q;
    logic                        stall;

    // ---------------- ID ----------------
    logic [3:0] id_op;
    logic [2:0] id_rd, id_rs1, id_rs2;
    logic       use_rs1, use_rs2, use_rd;
    logic       hit_ex, hit_mem;
    word_t      id_v1, id_v2, id_vd;

    assign id_op   = id_instr[15:12];
    assign id_rd   = id_instr[11:9];
    assign id_rs1  = id_instr[8:6];
    assign id_rs2  = id_instr[5:3];
    assign use_rs1 = (id_op >= OP_ADD) && (id_op <= OP_OUT);
    assign use_rs2 = (id_op >= OP_ADD) && (id_op <= OP_OR);
    assign use_rd  = (id_op == OP_STD);
    assign hit_ex  = src_hit(ex_q.rd, id_rs1, id_rs2, id_rd, use_rs1, use_rs2, use_rd);
    assign hit_mem = src_hit(mem_q.rd, id_rs1, id_rs2, id_rd, use_rs1, use_rs2, use_rd);

    always_comb begin
        stall = 1'b0;
        if (vld_pipe[0]) begin
            if (FORWARD_EN)
                stall = vld_pipe[1] && (ex_q.op == OP_LDM) && hit_ex;
            else
                stall = (vld_pipe[1] && writes_rd(ex_q.op) && hit_ex) ||
                        (vld_pipe[2] && mem_q.we && hit_mem);
        end
    end

    assign instr_ready = !stall;

    // Regfile read with write-through from the instruction retiring in WB
    always_comb begin
        id_v1 = rf[id_rs1];
        id_v2 = rf[id_rs2];
        id_vd = rf[id_rd];
        if (vld_pipe[3] && wb_q.we) begin
            if (wb_q.rd == id_rs1) id_v1 = wb_q.res;
            if (wb_q.rd == id_rs2) id_v2 = wb_q.res;
            if (wb_q.rd == id_rd)  id_vd = wb_q.res;
        end
    end

    always_comb begin
        ex_d     = '0;
        ex_d.op  = id_op;
        ex_d.rd  = id_rd;
        ex_d.rs1 = id_rs1;
        ex_d.rs2 = id_rs2;
        ex_d.imm = {{(DATA_WIDTH-6){id_instr[5]}}, id_instr[5:0]};
        ex_d.v1  = id_v1;
        ex_d.v2  = id_v2;
        ex_d.vd  = id_vd;
    end

    // ---------------- EX ----------------
    logic [2:0][2:0]            ex_src;
    logic [2:0][DATA_WIDTH-1:0] ex_raw, ex_opnd;
    word_t                      a, b, addb, res;
    logic [DATA_WIDTH:0]        sum;
    logic                       carry, upd_zn, upd_c;

    assign ex_src = {ex_q.rd, ex_q.rs2, ex_q.rs1};
    assign ex_raw = {ex_q.vd, ex_q.v2, ex_q.v1};

    // The younger producer (in MEM) wins over the older one (in WB)
    always_comb begin
        ex_opnd = ex_raw;
        if (FORWARD_EN) begin
            for (int i = 0; i < 3; i++) begin
                if (vld_pipe[2] && mem_q.we && mem_q.rd == ex_src[i])
                    ex_opnd[i] = mem_q.res;
                else if (vld_pipe[3] && wb_q.we && wb_q.rd == ex_src[i])
                    ex_opnd[i] = wb_q.res;
            end
        end
    end

    always_comb begin
        a      = ex_opnd[0];
        b      = ex_opnd[1];
        addb   = (ex_q.op == OP_ADD) ? b : ex_q.imm;
        sum    = {1'b0, a} + {1'b0, addb};
        res    = '0;
        carry  = 1'b0;
        upd_zn = 1'b0;
        upd_c  = 1'b0;
        case (ex_q.op)
            OP_ADD, OP_ADDI: begin res = sum[DATA_WIDTH-1:0]; carry = sum[DATA_WIDTH]; upd_zn = 1'b1; upd_c = 1'b1; end
            OP_SUB: begin res = a - b; carry = (a < b); upd_zn = 1'b1; upd_c = 1'b1; end
            OP_AND: begin res = a & b; upd_zn = 1'b1; end
            OP_OR:  begin res = a | b; upd_zn = 1'b1; end
            OP_NOT: begin res = ~a;    upd_zn = 1'b1; end
            OP_LDM, OP_STD: res = sum[DATA_WIDTH-1:0];
            OP_OUT: res = a;
            default: res = '0;
        endcase

        mem_d        = '0;
        mem_d.we     = writes_rd(ex_q.op);
        mem_d.st     = (ex_q.op == OP_STD);
        mem_d.ld     = (ex_q.op == OP_LDM);
        mem_d.is_out = (ex_q.op == OP_OUT);
        mem_d.rd     = ex_q.rd;
        mem_d.res    = res;
        mem_d.addr   = sum[AW-1:0];
        mem_d.wdata  = ex_opnd[2];
    end

    // ---------------- MEM ----------------
    word_t mem_rdata;
    assign mem_rdata = dmem[mem_q.addr];

    always_comb begin
        wb_d     = '0;
        wb_d.we  = mem_q.we;
        wb_d.rd  = mem_q.rd;
        wb_d.res = mem_q.ld ? mem_rdata : mem_q.res;
    end

    always_ff @(posedge clk) begin
        if (reset && vld_pipe[2] && mem_q.st)
            dmem[mem_q.addr] <= mem_q.wdata;
    end

    // ---------------- pipeline state ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vld_pipe  <= '0;
            id_instr  <= '0;
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            rf        <= '0;
            ccr_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (!stall) begin
                vld_pipe[0] <= instr_valid;
                if (instr_valid) id_instr <= instr;
            end
            vld_pipe[1] <= vld_pipe[0] && !stall;
            if (vld_pipe[0] && !stall) ex_q <= ex_d;
            vld_pipe[2] <= vld_pipe[1];
            mem_q       <= mem_d;
            vld_pipe[3] <= vld_pipe[2];
            wb_q        <= wb_d;

            if (vld_pipe[1]) begin
                if (upd_zn) ccr_q[1:0] <= {res[DATA_WIDTH-1], (res == '0)};
                if (upd_c)  ccr_q[2]   <= carry;
            end

            out_valid <= vld_pipe[2] && mem_q.is_out;
            if (vld_pipe[2] && mem_q.is_out) out_data <= mem_q.res;

            if (vld_pipe[3] && wb_q.we) rf[wb_q.rd] <= wb_q.res;
        end
    end

    assign ccr      = ccr_q;
    assign dbg_data = rf[dbg_addr];

endmodule

// File: tb/tb_pipelined_core_gen.sv
// Directed bench for pipelined_core_gen: three configurations, OUT results
// checked through a scoreboard of expected value and retire cycle.
module tb_pipelined_core_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        vi0, vi1, vi2;
    logic [15:0] in0, in1, in2;
    logic        rdy0, rdy1, rdy2;
    logic        ov0, ov1, ov2;
    logic [15:0] od0, od1;
    logic [31:0] od2;
    logic [2:0]  cc0, cc1, cc2;
    logic [2:0]  da0, da1, da2;
    logic [15:0] dd0, dd1;
    logic [31:0] dd2;

    pipelined_core_gen #(.DATA_WIDTH(16), .DMEM_DEPTH(256), .FORWARD_EN(1'b1)) u0 (
        .clk(clk), .reset(rst_n), .instr_valid(vi0), .instr(in0), .instr_ready(rdy0),
        .out_valid(ov0), .out_data(od0), .ccr(cc0), .dbg_addr(da0), .dbg_data(dd0));
    pipelined_core_gen #(.DATA_WIDTH(16), .DMEM_DEPTH(256), .FORWARD_EN(1'b0)) u1 (
        .clk(clk), .reset(rst_n), .instr_valid(vi1), .instr(in1), .instr_ready(rdy1),
        .out_valid(ov1), .out_data(od1), .ccr(cc1), .dbg_addr(da1), .dbg_data(dd1));
    pipelined_core_gen #(.DATA_WIDTH(32), .DMEM_DEPTH(16), .FORWARD_EN(1'b1)) u2 (
        .clk(clk), .reset(rst_n), .instr_valid(vi2), .instr(in2), .instr_ready(rdy2),
        .out_valid(ov2), .out_data(od2), .ccr(cc2), .dbg_addr(da2), .dbg_data(dd2));

    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND = 4'd3, ADDI = 4'd6,
                           LDM = 4'd7, STD = 4'd8, OUT = 4'd9;

    typedef struct packed { int cyc; logic [31:0] d; } exp_t;
    exp_t q0[$], q1[$], q2[$];

    int checks = 0, errors = 0, cyc = 0, low = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2);
        return {op, rd, rs1, rs2, 3'b000};
    endfunction

    function automatic logic [15:0] ii(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [5:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    task automatic drive(input int d, input logic v, input logic [15:0] ins);
        case (d)
            0: begin vi0 = v; in0 = ins; end
            1: begin vi1 = v; in1 = ins; end
            default: begin vi2 = v; in2 = ins; end
        endcase
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? rdy0 : (d == 1) ? rdy1 : rdy2;
    endfunction

    // Offer one instruction until accepted; lat>0 schedules an OUT result lat cycles after acceptance
    task automatic issue(input int d, input logic [15:0] ins, input int lat, input logic [31:0] exp_d);
        logic r;
        int   pre, n;
        exp_t e;
        n = 0;
        @(negedge clk);
        drive(d, 1'b1, ins);
        forever begin
            #1;
            r   = rdy(d);
            pre = cyc;
            if (!r) low++;
            n++;
            if (n > 50) begin
                chk($sformatf("d%0d_ready_timeout", d), {31'b0, r}, 32'd1);
                break;
            end
            @(posedge clk);
            if (r) break;
            @(negedge clk);
        end
        #1 drive(d, 1'b0, 16'h0);
        if (r && lat > 0) begin
            e.cyc = pre + 1 + lat;
            e.d   = exp_d;
            case (d)
                0: q0.push_back(e);
                1: q1.push_back(e);
                default: q2.push_back(e);
            endcase
        end
    endtask

    task automatic drain(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic dbg(input int d, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        case (d)
            0: da0 = a;
            1: da1 = a;
            default: da2 = a;
        endcase
        #1;
        v = (d == 0) ? {16'b0, dd0} : (d == 1) ? {16'b0, dd1} : dd2;
        chk($sformatf("d%0d_dbg_r%0d", d, a), v, exp);
    endtask

    task automatic mon(input int d, input logic ov, input logic [31:0] od);
        exp_t e;
        int   n;
        if (!ov) return;
        n = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (n == 0) begin
            chk($sformatf("d%0d_spurious_out_valid", d), {31'b0, ov}, 32'd0);
            return;
        end
        case (d)
            0: e = q0.pop_front();
            1: e = q1.pop_front();
            default: e = q2.pop_front();
        endcase
        chk($sformatf("d%0d_out_data", d), od, e.d);
        chk($sformatf("d%0d_out_cycle", d), cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        mon(0, ov0, {16'b0, od0});
        mon(1, ov1, {16'b0, od1});
        mon(2, ov2, od2);
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 16'h0); drive(1, 1'b0, 16'h0); drive(2, 1'b0, 16'h0);
        da0 = 3'd0; da1 = 3'd0; da2 = 3'd0;
        drain(2);
        chk("rst_ccr", {29'b0, cc0}, 32'd0);
        chk("rst_out_valid", {31'b0, ov0}, 32'd0);
        chk("rst_out_data", {16'b0, od0}, 32'd0);
        dbg(0, 3'd0, 32'd0);
        dbg(2, 3'd7, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("rel_ready0", {31'b0, rdy0}, 32'd1);
        chk("rel_ready1", {31'b0, rdy1}, 32'd1);
        chk("rel_ready2", {31'b0, rdy2}, 32'd1);

        // forwarded back-to-back ALU chain
        low = 0;
        issue(0, ii(ADDI, 3'd1, 3'd0, 6'd5), 0, 0);
        issue(0, ii(ADDI, 3'd2, 3'd0, 6'd3), 0, 0);
        issue(0, rr(ADD, 3'd3, 3'd1, 3'd2), 0, 0);
        issue(0, rr(OUT, 3'd0, 3'd3, 3'd0), 3, 32'd8);
        issue(0, 16'h0000, 0, 0);
        chk("t1_ready_low", low, 32'd0);
        drain(8);
        dbg(0, 3'd3, 32'd8);

        // store, load, load-use interlock
        low = 0;
        issue(0, ii(ADDI, 3'd1, 3'd0, 6'd5), 0, 0);
        issue(0, ii(STD, 3'd1, 3'd0, 6'd4), 0, 0);
        issue(0, ii(LDM, 3'd4, 3'd0, 6'd4), 0, 0);
        issue(0, rr(ADD, 3'd5, 3'd4, 3'd4), 0, 0);
        issue(0, rr(OUT, 3'd0, 3'd5, 3'd0), 3, 32'd10);
        issue(0, {NOP, 12'h0}, 0, 0);
        chk("t2_ready_low", low, 32'd1);
        drain(8);
        dbg(0, 3'd4, 32'd5);

        // SUB borrow and flags, then AND keeps C
        issue(0, rr(SUB, 3'd6, 3'd2, 3'd1), 0, 0);
        issue(0, rr(OUT, 3'd0, 3'd6, 3'd0), 3, 32'h0000_FFFE);
        drain(8);
        chk("t3_ccr_sub", {29'b0, cc0}, 32'b110);
        issue(0, rr(AND, 3'd7, 3'd1, 3'd1), 0, 0);
        drain(8);
        chk("t3_ccr_and", {29'b0, cc0}, 32'b100);
        dbg(0, 3'd7, 32'd5);

        // no forwarding: RAW hazards stall until producer reaches WB
        low = 0;
        issue(1, ii(ADDI, 3'd1, 3'd0, 6'd5), 0, 0);
        issue(1, ii(ADDI, 3'd2, 3'd0, 6'd3), 0, 0);
        issue(1, rr(ADD, 3'd3, 3'd1, 3'd2), 0, 0);
        issue(1, rr(OUT, 3'd0, 3'd3, 3'd0), 5, 32'd8);
        issue(1, 16'h0000, 0, 0);
        chk("t4_ready_low", low, 32'd4);
        drain(10);
        dbg(1, 3'd3, 32'd8);

        // 32-bit datapath, 16-word memory with address wrap
        issue(2, ii(ADDI, 3'd1, 3'd0, 6'h3F), 0, 0);
        drain(8);
        dbg(2, 3'd1, 32'hFFFF_FFFF);
        issue(2, ii(ADDI, 3'd1, 3'd1, 6'd1), 0, 0);
        drain(8);
        dbg(2, 3'd1, 32'd0);
        chk("t5_ccr_wrap", {29'b0, cc2}, 32'b101);
        issue(2, ii(ADDI, 3'd3, 3'd0, 6'h39), 0, 0);
        issue(2, ii(STD, 3'd3, 3'd0, 6'd20), 0, 0);
        issue(2, ii(LDM, 3'd4, 3'd0, 6'd4), 0, 0);
        issue(2, rr(OUT, 3'd0, 3'd4, 3'd0), 4, 32'hFFFF_FFF9);
        drain(10);
        dbg(2, 3'd4, 32'hFFFF_FFF9);
        chk("sb_empty", q0.size() + q1.size() + q2.size(), 32'd0);

        // reset with ADD in MEM and OUT in EX
        issue(0, rr(ADD, 3'd3, 3'd6, 3'd6), 0, 0);
        issue(0, rr(OUT, 3'd0, 3'd3, 3'd0), 0, 0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        drain(3);
        chk("t6_ccr", {29'b0, cc0}, 32'd0);
        chk("t6_out_valid", {31'b0, ov0}, 32'd0);
        chk("t6_out_data", {16'b0, od0}, 32'd0);
        for (int r = 0; r < 8; r++) dbg(0, 3'(r), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("t6_ready", {31'b0, rdy0}, 32'd1);
        drain(8);
        chk("t6_ccr_after", {29'b0, cc0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_core_gen.md
Name: pipelined_core_gen

Overview:
Parametrised successor to the fixed 16-bit pipelined processor datapath. It accepts instructions over a valid/ready stream and runs them through four stages: ID, EX, MEM, WB. It has an internal 8-entry register file, data memory, CCR, selectable forwarding, and load-use stall logic. OUT instructions drive a registered output port, so the block can serve as a drop-in datapath behind any fetch unit.

Parameters:
DATA_WIDTH, 16, datapath, register, memory word and out_data width (>=8)
DMEM_DEPTH, 256, data memory words (power of two); address = low log2(DMEM_DEPTH) bits of effective address, wraps
FORWARD_EN, 1, 1 = EX/MEM and MEM/WB forwarding; 0 = stall on every RAW hazard

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
instr_valid  in  1  instr holds a valid instruction
instr  in  16  [15:12] op, [11:9] rd, [8:6] rs1, [5:3] rs2, [5:0] imm6 (sign-extended)
instr_ready  out  1  core accepts instr this cycle
out_valid  out  1  one-cycle pulse, OUT instruction retired
out_data  out  DATA_WIDTH  value of OUT source register
ccr  out  3  {C,N,Z}
dbg_addr  in  3  debug register-file read address
dbg_data  out  DATA_WIDTH  combinational regfile[dbg_addr]

Behaviour:
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs1+rs2.
  - 2 SUB rd=rs1-rs2.
  - 3 AND.
  - 4 OR.
  - 5 NOT rd=~rs1.
  - 6 ADDI rd=rs1+sext(imm6).
  - 7 LDM rd=mem[rs1+sext(imm6)].
  - 8 STD mem[rs1+sext(imm6)]=R[rd].
  - 9 OUT out_data=R[rs1].
  - 10-15 execute as NOP.
- Handshake: instruction accepted at an edge where instr_valid && instr_ready, then loaded into the ID register. instr_ready = !stall. instr_ready is 1 whenever ID is empty or will advance.
- Timing relative to acceptance edge E0:
  - ID during cycle after E0.
  - EX after E1.
  - MEM after E2.
  - WB after E3.
  - Regfile written at E4.
- Regfile write-through: a WB write to the register ID is reading delivers the new value to ID in the same cycle.
- Forwarding (FORWARD_EN=1): EX operand priority is EX/MEM result, then MEM/WB result, then the register-file value.
- Load-use: if the EX instruction is LDM and the ID instruction reads its rd, ID holds one cycle, a bubble enters EX, and instr_ready=0 for exactly that cycle.
- Source registers read per op:
  - ADD/SUB/AND/OR read rs1 and rs2.
  - NOT/ADDI/LDM/OUT read rs1.
  - STD reads rs1 and rd.
- FORWARD_EN=0: ID stalls while any instruction in EX or MEM writes one of the ID sources. With write-through, the consumer issues the cycle the producer is in WB.
- Arithmetic: mod 2^DATA_WIDTH.
- ADD/ADDI: C = carry-out.
- SUB: C = borrow (rs1<rs2 unsigned).
- Z = result==0; N = result MSB.
- CCR update: ADD/SUB/ADDI/AND/OR/NOT update Z and N at the EX→MEM edge. AND/OR/NOT keep C. Other ops leave CCR unchanged.
- Memory: synchronous write in MEM; combinational read in MEM, registered into MEM/WB. Contents are not reset.
- STD in MEM followed by LDM to the same address in the next cycle returns the stored value.
- OUT: out_valid=1 and out_data=R[rs1] (forwarded) in the cycle after E3, i.e. 3 cycles after acceptance for the no-stall case. out_valid=0 otherwise; out_data holds its last value.
- Reset (async, active-low):
  - All stage valid bits 0; in-flight instructions discarded; no store commits.
  - Regfile 0, ccr 0, out_valid 0, out_data 0.
  - instr_ready=1 from the first edge after deassertion.
- Simultaneous events: a stall and an incoming valid means instr is not consumed and the source must hold it. Bubbles never write the regfile, memory or CCR.

Test Plan:
1. FORWARD_EN=1, back-to-back ADDI r1,r0,5; ADDI r2,r0,3; ADD r3,r1,r2; OUT r3 -> instr_ready never drops; out_data=8 with out_valid pulse 3 cycles after OUT accepted.
2. ADDI r1,r0,5; STD r1,[r0+4]; LDM r4,[r0+4]; ADD r5,r4,r4; OUT r5 -> instr_ready low exactly 1 cycle (while ADD is in ID); out_data=10.
3. r1=5, r2=3, SUB r6,r2,r1; OUT r6 -> out_data=0xFFFE, ccr C=1 N=1 Z=0; following AND r7,r1,r1 -> C stays 1, N=0, Z=0.
4. FORWARD_EN=0, sequence of test 1 -> ADD held 2 cycles and OUT held 2 cycles; out_data=8; total 4 ready-low cycles.
5. DATA_WIDTH=32: ADDI r1,r0,-1 (imm 0x3F) -> dbg r1=0xFFFFFFFF; ADDI r1,r1,1 -> r1=0, Z=1, C=1. DMEM_DEPTH=16: STD to addr 20 then LDM addr 4 -> same value (wrap).
6. reset driven low while ADD and OUT are in EX and MEM -> out_valid never pulses, ccr=0, all dbg reads 0, instr_ready=1 one edge after release.
